// File: rtl/playseq_unidade_controle.sv
// playseq_unidade_controle: Moore FSM that sequences the PlaySeq datapath through preview, readback, recording and round counting
module playseq_unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       igual,
  input  logic       enderecoIgualSequencia,
  input  logic       fimS,
  input  logic       tem_jogada,
  input  logic       controle_timeout,
  input  logic       controle_timeout_led,
  input  logic       pare,
  input  logic       vai_escrever,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraS,
  output logic       carregaS,
  output logic       contaS,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraT_leds,
  output logic       contaT_leds,
  output logic       zeraJ,
  output logic       contaJ,
  output logic       controla_leds,
  output logic       fase_preview,
  output logic       ram_escreve,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [4:0] db_estado
);
  typedef enum logic [4:0] {
    inicial           = 5'h00,
    preparacao        = 5'h01,
    carrega           = 5'h02,
    inicia_rodada     = 5'h03,
    mostra_led        = 5'h04,
    zera_led          = 5'h05,
    apaga_led         = 5'h06,
    proximo_led       = 5'h07,
    inicia_jogadas    = 5'h08,
    espera_jogada     = 5'h09,
    registra          = 5'h0A,
    compara           = 5'h0B,
    proximo_endereco  = 5'h0C,
    proxima_sequencia = 5'h0D,
    prepara_escrita   = 5'h0E,
    espera_escrita    = 5'h0F,
    registra_escrita  = 5'h10,
    grava             = 5'h11,
    fim_rodada        = 5'h12,
    verifica_rodada   = 5'h13,
    fim_acertou       = 5'h14,
    fim_errou         = 5'h15,
    fim_timeout       = 5'h16
  } state_t;
  localparam logic [19:0] m_ze  = 20'h80000;
  localparam logic [19:0] m_ce  = 20'h40000;
  localparam logic [19:0] m_zs  = 20'h20000;
  localparam logic [19:0] m_cgs = 20'h10000;
  localparam logic [19:0] m_cs  = 20'h08000;
  localparam logic [19:0] m_zr  = 20'h04000;
  localparam logic [19:0] m_rr  = 20'h02000;
  localparam logic [19:0] m_zt  = 20'h01000;
  localparam logic [19:0] m_ct  = 20'h00800;
  localparam logic [19:0] m_ztl = 20'h00400;
  localparam logic [19:0] m_ctl = 20'h00200;
  localparam logic [19:0] m_zj  = 20'h00100;
  localparam logic [19:0] m_cj  = 20'h00080;
  localparam logic [19:0] m_led = 20'h00040;
  localparam logic [19:0] m_fp  = 20'h00020;
  localparam logic [19:0] m_ram = 20'h00010;
  localparam logic [19:0] m_pr  = 20'h00008;
  localparam logic [19:0] m_ac  = 20'h00004;
  localparam logic [19:0] m_er  = 20'h00002;
  localparam logic [19:0] m_to  = 20'h00001;
  state_t      state, nxt;
  logic [19:0] out_q;
  function automatic logic [19:0] decode(input state_t s);
    case (s)
      preparacao:        return m_ze | m_zs | m_zr | m_zt | m_ztl | m_zj;
      carrega:           return m_cgs;
      inicia_rodada:     return m_ze | m_ztl | m_fp;
      mostra_led:        return m_fp | m_led | m_ctl;
      zera_led:          return m_fp | m_ztl;
      apaga_led:         return m_fp | m_ctl;
      proximo_led:       return m_fp | m_ce | m_ztl;
      inicia_jogadas:    return m_ze | m_zt;
      espera_jogada:     return m_ct;
      registra:          return m_rr | m_zt;
      proximo_endereco:  return m_ce;
      proxima_sequencia: return m_cs;
      prepara_escrita:   return m_ce | m_zt;
      espera_escrita:    return m_ct;
      registra_escrita:  return m_rr;
      grava:             return m_ram;
      fim_rodada:        return m_cj;
      fim_acertou:       return m_pr | m_ac;
      fim_errou:         return m_pr | m_er;
      fim_timeout:       return m_pr | m_to;
      default:           return '0;
    endcase
  endfunction
  // next-state selection from the current state and datapath status
  always_comb begin
    nxt = inicial;
    case (state)
      inicial:           nxt = iniciar ? preparacao : inicial;
      preparacao:        nxt = carrega;
      carrega:           nxt = inicia_rodada;
      inicia_rodada:     nxt = mostra_led;
      mostra_led:        nxt = controle_timeout_led ? zera_led : mostra_led;
      zera_led:          nxt = apaga_led;
      apaga_led:         nxt = !controle_timeout_led ? apaga_led : enderecoIgualSequencia ? inicia_jogadas : proximo_led;
      proximo_led:       nxt = mostra_led;
      inicia_jogadas:    nxt = espera_jogada;
      espera_jogada:     nxt = tem_jogada ? registra : controle_timeout ? fim_timeout : espera_jogada;
      registra:          nxt = compara;
      compara:           nxt = !igual ? fim_errou : !enderecoIgualSequencia ? proximo_endereco : fimS ? fim_rodada : vai_escrever ? prepara_escrita : proxima_sequencia;
      proximo_endereco:  nxt = espera_jogada;
      proxima_sequencia: nxt = inicia_rodada;
      prepara_escrita:   nxt = espera_escrita;
      espera_escrita:    nxt = tem_jogada ? registra_escrita : controle_timeout ? fim_timeout : espera_escrita;
      registra_escrita:  nxt = grava;
      grava:             nxt = proxima_sequencia;
      fim_rodada:        nxt = verifica_rodada;
      verifica_rodada:   nxt = pare ? fim_acertou : carrega;
      fim_acertou,
      fim_errou,
      fim_timeout:       nxt = iniciar ? preparacao : state;
      default:           nxt = inicial;
    endcase
  end
  // state register with outputs registered as the decode of the incoming state
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= inicial;
      out_q <= '0;
    end else begin
      state <= nxt;
      out_q <= decode(nxt);
    end
  end
  assign {zeraE, contaE, zeraS, carregaS, contaS, zeraR, registraR, zeraT, contaT, zeraT_leds,
          contaT_leds, zeraJ, contaJ, controla_leds, fase_preview, ram_escreve, pronto, acertou,
          errou, timeout} = out_q;
  assign db_estado = state;
endmodule

// File: tb/tb_playseq_unidade_controle.sv
// tb_playseq_unidade_controle: directed and randomized check of the PlaySeq control FSM against a behavioural model
module tb_playseq_unidade_controle;
  logic clock = 1'b0, reset = 1'b0, iniciar = 1'b0, igual = 1'b0, eis = 1'b0, fimS = 1'b0;
  logic tem = 1'b0, to = 1'b0, ctl = 1'b0, pare = 1'b0, vai = 1'b0;
  logic zeraE, contaE, zeraS, carregaS, contaS, zeraR, registraR, zeraT, contaT, zeraT_leds;
  logic contaT_leds, zeraJ, contaJ, controla_leds, fase_preview, ram_escreve, pronto, acertou, errou, timeout;
  logic [4:0]  db_estado;
  logic [19:0] dut_o;
  int checks = 0, errors = 0;
  int ms = 0;
  bit mvalid = 1'b0;

  playseq_unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .igual(igual),
    .enderecoIgualSequencia(eis), .fimS(fimS), .tem_jogada(tem), .controle_timeout(to),
    .controle_timeout_led(ctl), .pare(pare), .vai_escrever(vai),
    .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .carregaS(carregaS), .contaS(contaS),
    .zeraR(zeraR), .registraR(registraR), .zeraT(zeraT), .contaT(contaT),
    .zeraT_leds(zeraT_leds), .contaT_leds(contaT_leds), .zeraJ(zeraJ), .contaJ(contaJ),
    .controla_leds(controla_leds), .fase_preview(fase_preview), .ram_escreve(ram_escreve),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );

  assign dut_o = {zeraE, contaE, zeraS, carregaS, contaS, zeraR, registraR, zeraT, contaT, zeraT_leds,
                  contaT_leds, zeraJ, contaJ, controla_leds, fase_preview, ram_escreve, pronto, acertou,
                  errou, timeout};

  always #5 clock = ~clock;

  function automatic int mnext(input int s);
    if (s == 0) return iniciar ? 1 : 0;
    if (s >= 1 && s <= 3) return s + 1;
    if (s == 4) return ctl ? 5 : 4;
    if (s == 5) return 6;
    if (s == 6) return !ctl ? 6 : (eis ? 8 : 7);
    if (s == 7) return 4;
    if (s == 8 || s == 12) return 9;
    if (s == 9) return tem ? 10 : (to ? 22 : 9);
    if (s == 10) return 11;
    if (s == 11) begin
      if (!igual) return 21;
      if (!eis) return 12;
      if (fimS) return 18;
      return vai ? 14 : 13;
    end
    if (s == 13) return 3;
    if (s == 14) return 15;
    if (s == 15) return tem ? 16 : (to ? 22 : 15);
    if (s == 16) return 17;
    if (s == 17) return 13;
    if (s == 18) return 19;
    if (s == 19) return pare ? 20 : 2;
    if (s >= 20 && s <= 22) return iniciar ? 1 : s;
    return 0;
  endfunction

  // order: zeraE contaE zeraS carregaS contaS zeraR registraR zeraT contaT zeraT_leds
  //        contaT_leds zeraJ contaJ controla_leds fase_preview ram_escreve pronto acertou errou timeout
  function automatic logic [19:0] mout(input int s);
    logic [19:0] o;
    o = '0;
    case (s)
      1:  begin o[19] = 1; o[17] = 1; o[14] = 1; o[12] = 1; o[10] = 1; o[8] = 1; end
      2:  o[16] = 1;
      3:  begin o[19] = 1; o[10] = 1; o[5] = 1; end
      4:  begin o[5] = 1; o[6] = 1; o[9] = 1; end
      5:  begin o[5] = 1; o[10] = 1; end
      6:  begin o[5] = 1; o[9] = 1; end
      7:  begin o[5] = 1; o[18] = 1; o[10] = 1; end
      8:  begin o[19] = 1; o[12] = 1; end
      9:  o[11] = 1;
      10: begin o[13] = 1; o[12] = 1; end
      12: o[18] = 1;
      13: o[15] = 1;
      14: begin o[18] = 1; o[12] = 1; end
      15: o[11] = 1;
      16: o[13] = 1;
      17: o[4] = 1;
      18: o[7] = 1;
      20: begin o[3] = 1; o[2] = 1; end
      21: begin o[3] = 1; o[1] = 1; end
      22: begin o[3] = 1; o[0] = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // reference model advances on the same edge as the DUT
  always @(posedge clock) begin
    if (!reset) begin
      ms = 0;
      mvalid = 1'b1;
    end else if (mvalid) ms = mnext(ms);
  end

  // cycle-by-cycle comparison, away from the active edge
  always @(negedge clock) begin
    if (mvalid) begin
      checks++;
      if (db_estado !== 5'(ms) || dut_o !== mout(ms)) begin
        errors++;
        $display("FAIL model t=%0t state=%0h outs=%h required state=%0h outs=%h", $time, db_estado, dut_o, ms, mout(ms));
      end
    end
  end

  task automatic go(input logic [4:0] e);
    @(posedge clock);
    #1;
    checks++;
    if (db_estado !== e) begin
      errors++;
      $display("FAIL state actual=%0h required=%0h", db_estado, e);
    end
  endtask

  task automatic flag(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", n, a, e);
    end
  endtask

  task automatic to_compara;
    go(4); ctl = 1; go(5); go(6); go(8); ctl = 0; go(9); tem = 1; go(10); tem = 0;
  endtask

  initial begin
    repeat (3) go(5'h00);
    checks++;
    if (dut_o !== 20'h0) begin
      errors++;
      $display("FAIL reset_outs actual=%h required=%h", dut_o, 20'h0);
    end
    reset = 1; go(5'h00); go(5'h00);
    iniciar = 1; go(5'h01); iniciar = 0; go(5'h02); flag("carregaS_on", carregaS, 1'b1);
    go(5'h03); flag("carregaS_off", carregaS, 1'b0); go(5'h04);
    ctl = 1; go(5'h05); go(5'h06); go(5'h07); flag("contaE_on", contaE, 1'b1);
    go(5'h04); flag("contaE_off", contaE, 1'b0); go(5'h05); eis = 1; go(5'h06); go(5'h08);
    ctl = 0; eis = 0; go(5'h09);
    tem = 1; to = 1; go(5'h0A); tem = 0; to = 0; go(5'h0B);
    igual = 0; go(5'h15); flag("pronto_err", pronto, 1'b1); flag("errou", errou, 1'b1);
    iniciar = 1; go(5'h01); iniciar = 0; go(5'h02); go(5'h03);
    eis = 1; igual = 1; vai = 1;
    to_compara; go(5'h0B); go(5'h0E); go(5'h0F);
    tem = 1; go(5'h10); tem = 0; go(5'h11); flag("ram_on", ram_escreve, 1'b1);
    go(5'h0D); flag("ram_off", ram_escreve, 1'b0); vai = 0; go(5'h03);
    fimS = 1; to_compara; go(5'h0B); go(5'h12); flag("contaJ", contaJ, 1'b1);
    pare = 1; go(5'h13); go(5'h14); flag("acertou", acertou, 1'b1); pare = 0;
    iniciar = 1; go(5'h01); iniciar = 0; go(5'h02); go(5'h03);
    to_compara; go(5'h0B); go(5'h12); go(5'h13); go(5'h02);
    fimS = 0; eis = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clock);
      #1;
      reset   = $urandom_range(99) != 0;
      iniciar = $urandom_range(4) == 0;
      igual   = $urandom_range(9) != 0;
      eis     = $urandom_range(2) == 0;
      fimS    = $urandom_range(3) == 0;
      tem     = $urandom_range(3) == 0;
      to      = $urandom_range(19) == 0;
      ctl     = $urandom_range(1) == 1;
      pare    = $urandom_range(2) == 0;
      vai     = $urandom_range(1) == 1;
    end
    @(posedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/playseq_unidade_controle.md
Name: playseq_unidade_controle

Overview:
- Moore FSM that sequences the PlaySeq datapath (playseq_fluxo_dados).
- Runs one game: LED preview of the current sequence, then readback of the player's presses, sequence growth, optional recording of new steps into the RAM memory, and round counting up to the level limit.
- Drives every zera/conta/carrega/registra strobe of the datapath and reports the game outcome.

Parameters:
- None. Timeout lengths live in the datapath counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low. Sampled on the rising edge of clock. While 0, the FSM goes to inicial.
- iniciar  in  1  start request.
- igual, enderecoIgualSequencia, fimS, tem_jogada, controle_timeout, controle_timeout_led, pare, vai_escrever  in  1 each  datapath status.
- zeraE, contaE, zeraS, carregaS, contaS, zeraR, registraR, zeraT, contaT, zeraT_leds, contaT_leds, zeraJ, contaJ  out  1 each  datapath strobes.
- controla_leds, fase_preview, ram_escreve  out  1 each  datapath controls.
- pronto, acertou, errou, timeout  out  1 each  outcome flags.
- db_estado  out  5  current state code.

Behaviour:
- Outputs are a pure decode of the state register. Any output not listed for a state is 0.
- Reset: state = inicial (00). All outputs are 0, db_estado = 00.
- Reset asserted mid-game takes effect at the next edge, from any state.
- States, with codes and asserted outputs:
  - inicial 00: none.
  - preparacao 01: zeraE, zeraS, zeraR, zeraT, zeraT_leds, zeraJ.
  - carrega 02: carregaS.
  - inicia_rodada 03: zeraE, zeraT_leds, fase_preview.
  - mostra_led 04: fase_preview, controla_leds, contaT_leds.
  - zera_led 05: fase_preview, zeraT_leds.
  - apaga_led 06: fase_preview, contaT_leds.
  - proximo_led 07: fase_preview, contaE, zeraT_leds.
  - inicia_jogadas 08: zeraE, zeraT.
  - espera_jogada 09: contaT.
  - registra 0A: registraR, zeraT.
  - compara 0B: none.
  - proximo_endereco 0C: contaE.
  - proxima_sequencia 0D: contaS.
  - prepara_escrita 0E: contaE, zeraT.
  - espera_escrita 0F: contaT.
  - registra_escrita 10: registraR.
  - grava 11: ram_escreve.
  - fim_rodada 12: contaJ.
  - verifica_rodada 13: none.
  - fim_acertou 14: pronto, acertou.
  - fim_errou 15: pronto, errou.
  - fim_timeout 16: pronto, timeout.
- Transitions:
  - inicial: iniciar -> preparacao.
  - preparacao -> carrega -> inicia_rodada -> mostra_led. Each is unconditional, one cycle.
  - mostra_led: controle_timeout_led -> zera_led. zera_led -> apaga_led.
  - apaga_led: on controle_timeout_led, enderecoIgualSequencia -> inicia_jogadas; otherwise -> proximo_led.
  - proximo_led -> mostra_led.
  - inicia_jogadas -> espera_jogada.
  - espera_jogada: tem_jogada -> registra. Otherwise controle_timeout -> fim_timeout. If both are high in the same cycle, tem_jogada wins.
  - registra -> compara. This gives the register plus synchronous memory one cycle before igual is sampled.
  - compara, checked in priority order:
    - !igual -> fim_errou.
    - !enderecoIgualSequencia -> proximo_endereco -> espera_jogada.
    - fimS -> fim_rodada.
    - vai_escrever -> prepara_escrita.
    - otherwise -> proxima_sequencia.
  - prepara_escrita -> espera_escrita.
  - espera_escrita: tem_jogada -> registra_escrita; otherwise controle_timeout -> fim_timeout.
  - registra_escrita -> grava -> proxima_sequencia.
  - proxima_sequencia -> inicia_rodada. The preview replays the sequence, now one step longer.
  - fim_rodada -> verifica_rodada. pare is only sampled one cycle after contaJ.
  - verifica_rodada: pare -> fim_acertou; otherwise -> carrega.
  - fim_acertou, fim_errou, fim_timeout: hold until iniciar -> preparacao.
- iniciar is ignored in every other state.
- ram_escreve is asserted for exactly one cycle per recorded step, and only on the path through grava.
- Unused state codes (17-1F) -> inicial on the next edge, with all outputs 0.

Test Plan:
- Reset held at 0 for 3 cycles, then released with iniciar=0 -> db_estado=00, all outputs 0, and the FSM stays in inicial.
- Release reset, pulse iniciar, with enderecoIgualSequencia=0 for one preview address -> db_estado goes 01,02,03,04. carregaS is high exactly one cycle (state 02). controle_timeout_led pulses walk 04->05->06->07->04, and contaE is high one cycle (state 07).
- In espera_jogada, raise tem_jogada and controle_timeout in the same cycle -> next state is 0A, then 0B, not 16.
- Compara with igual=0 -> 15 with pronto=1 and errou=1. Then pulse iniciar -> 01.
- Compara with igual=1, enderecoIgualSequencia=1, fimS=0, vai_escrever=1 -> states 0E,0F. After tem_jogada -> 10,11 with ram_escreve=1 for exactly one cycle, then 0D,03.
- Compara with igual=1, enderecoIgualSequencia=1, fimS=1, and pare=1 presented in state 13 -> 12 (contaJ=1), 13, 14 (acertou=1). Repeating the round with pare=0 goes 13 -> 02 instead.
